instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the single-cycle MIPS datapath; it sits directly upstream of the opcode decoder. It holds the program counter and fetches one 32-bit word per instruction from a variable-latency instruction memory. It presents the instruction and its 6-bit opcode to the decoder with a valid/ready handshake. When the instruction is accepted, it computes the next PC from the decoder's branch/jump outputs and the ALU zero flag.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word-aligned).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  32  fetch address; equals pc.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word.
- instr  out  32  fetched instruction, held stable while instr_valid.
- opcode  out  6  instr[31:26]; drives the decoder.
- instr_pc  out  32  address of instr.
- instr_valid  out  1  instr/opcode/instr_pc are meaningful.
- instr_ready  in  1  downstream retires the instruction this cycle.
- branch  in  1  decoder branch output for the current instr.
- jump  in  1  decoder jump output for the current instr.
- zero  in  1  ALU zero flag for the current instr.
- retired  out  32  count of accepted instructions.
- proto_err  out  1  sticky: imem_rvalid seen outside WAIT.

## Operation
- FSM states: REQ, WAIT, VALID.
  - REQ: imem_req=1 with imem_addr=pc for exactly one cycle, then go to WAIT.
  - WAIT: on imem_rvalid, capture imem_rdata into instr and go to VALID; otherwise stay.
  - VALID: instr_valid=1. On instr_ready, load pc<=next_pc, increment retired, and go to REQ.
- next_pc, evaluated in the accept cycle:
  - pc4 = pc+4, mod 2^32.
  - jump=1 → {pc4[31:28], instr[25:0], 2'b00}. Jump has priority over branch; the decoder asserts branch together with jump on opcode 000010.
  - else branch=1 and zero=1 → pc4 + (sign_extend(instr[15:0])<<2), mod 2^32.
  - else → pc4.
- branch, jump and zero are sampled only when instr_valid and instr_ready are both 1; they are ignored otherwise.
- instr_ready while instr_valid=0 has no effect.
- imem_rvalid in REQ or VALID is ignored for data and sets proto_err. proto_err clears only on reset.
- Wrap-around:
  - pc 32'hFFFF_FFFC with no branch or jump → 32'h0000_0000.
  - retired wraps 32'hFFFF_FFFF → 0.
- Reset values: pc=RESET_PC, state=REQ, instr=0, instr_pc=0, instr_valid=0, imem_req=0, retired=0, proto_err=0.
- Reset mid-operation: all state clears asynchronously. An outstanding memory response is discarded; the memory is reset by the same rst_n.

## Timing
- imem_req is registered; it asserts in the first clk edge after rst_n deasserts.
- Fetch latency: request cycle → rvalid after N≥1 cycles → instr_valid asserts the cycle after rvalid.
- Minimum loop with 1-cycle memory and instr_ready tied high: 4 cycles per instruction (REQ, WAIT, VALID, accept→REQ).
- All outputs are registered except opcode, which is a wire slice of instr.
- pc and retired update on the accept edge. The next imem_req, carrying the new pc, follows in the next cycle.

## Structure
- Shared package mips_pkg holds:
  - Opcode constants: OP_RTYPE 000000, OP_ADDI 001000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010.
  - The fetch FSM state enum.
  - The default reset vector.
- One sub-module: next_pc, purely combinational. Inputs pc, instr, branch, jump, zero; output next_pc.
- FSM, pc, instruction register and counters live in instr_fetch.

## Test plan
- Reset then sequential fetch, 1-cycle memory, instr_ready=1: imem_addr 0x0, 0x4, 0x8 on successive REQ cycles; retired=3 after the third accept.
- Taken beq: pc=0x10, instr imm=0xFFFE, branch=1, zero=1 → next imem_addr=0x0C. With zero=0 → next imem_addr=0x14.
- Jump with branch also asserted: pc=0x1000_0000, instr[25:0]=0x40 → next imem_addr=0x1000_0100.
- Backpressure: instr_ready=0 for 5 cycles → instr, instr_pc and instr_valid stable and no imem_req. Release → pc advances exactly once.
- Wrap: RESET_PC=0xFFFF_FFFC, plain instruction accepted → next imem_addr=0x0000_0000.
- Async reset asserted in WAIT, then a stray imem_rvalid in REQ after release → outputs return to reset values, proto_err=1, instr unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM states, reset vector and
// the immediate/target helpers used by the next-PC logic.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    // Word offset of a branch: sign-extended 16-bit immediate scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection for the instruction being retired:
// jump beats taken branch, which beats sequential pc+4.
module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        zero_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        unused_opcode;

    assign pc4       = pc_i + PC_STEP;
    assign br_target = pc4 + branch_offset(instr_i[15:0]);
    assign j_target  = jump_target(pc4[31:28], instr_i[25:0]);

    // The opcode field is decoded upstream; only branch/jump flags matter here.
    assign unused_opcode = ^instr_i[31:26];

    always_comb begin
        next_pc_o = pc4;
        if (jump_i) begin
            next_pc_o = j_target;
        end else if (branch_i && zero_i) begin
            next_pc_o = br_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, variable-latency fetch FSM, instruction
// register with valid/ready handoff to the decoder, retire counter.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_REQ   | issue a one-cycle fetch request for pc (visible next cycle)
// ST_WAIT  | waiting for imem_rvalid; capture instruction on arrival
// ST_VALID | instruction presented to decoder; retire on instr_ready
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] retired,
    output logic        proto_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  retired_q, retired_d;
    logic         instr_valid_q, instr_valid_d;
    logic         imem_req_q, imem_req_d;
    logic         proto_err_q, proto_err_d;
    logic [31:0]  next_pc_w;

    next_pc u_next_pc (
        .pc_i      (pc_q),
        .instr_i   (instr_q),
        .branch_i  (branch),
        .jump_i    (jump),
        .zero_i    (zero),
        .next_pc_o (next_pc_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            retired_q     <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            retired_q     <= retired_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            proto_err_q   <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        retired_d   = retired_q;
        imem_req_d  = 1'b0;
        // Any response outside WAIT is a memory protocol violation; data is dropped.
        proto_err_d = proto_err_q | (imem_rvalid && (state_q != ST_WAIT));

        case (state_q)
            ST_REQ: begin
                imem_req_d = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ST_VALID;
                end
            end
            ST_VALID: begin
                if (instr_ready) begin
                    pc_d      = next_pc_w;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        instr_valid_d = (state_d == ST_VALID);
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign retired     = retired_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of instructions with expected next fetch address,
// scoreboard queues for fetch addresses and presented instructions.
module tb_instr_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] retired;
    logic        proto_err;

    logic [31:0] imem_addr_w;
    logic        unused_w_req;
    logic [31:0] unused_w_instr;
    logic [5:0]  unused_w_opcode;
    logic [31:0] unused_w_ipc;
    logic        unused_w_valid;
    logic [31:0] unused_w_retired;
    logic        unused_w_perr;

    typedef struct {
        logic [31:0] instr;
        logic        b;
        logic        j;
        logic        z;
        int          lat;
        int          stall;
        logic        rdy_early;
        logic [31:0] exp_next;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_t;

    logic [31:0] exp_pc_q[$];
    fetch_t      exp_f_q[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
        .opcode(opcode), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .branch(branch), .jump(jump), .zero(zero),
        .retired(retired), .proto_err(proto_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_req(unused_w_req), .imem_addr(imem_addr_w),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(unused_w_instr),
        .opcode(unused_w_opcode), .instr_pc(unused_w_ipc), .instr_valid(unused_w_valid),
        .instr_ready(instr_ready), .branch(branch), .jump(jump), .zero(zero),
        .retired(unused_w_retired), .proto_err(unused_w_perr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (imem_req === 1'b1);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got no imem_req want imem_req within 40 cycles");
        end
    endtask

    task automatic check_fetch_addr(input string name, output logic [31:0] e_pc);
        e_pc = '0;
        if (exp_pc_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got empty scoreboard want expected address", name);
        end else begin
            e_pc = exp_pc_q.pop_front();
            chk(name, imem_addr, e_pc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000 time units");
        $fatal(1);
    end

    initial begin
        vec_t        vt[12];
        fetch_t      f;
        bit          ok;
        logic [31:0] e_pc;

        vt[0]  = '{32'h2001_0005, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 32'h0000_0004};
        vt[1]  = '{32'h8C22_0000, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 32'h0000_0008};
        vt[2]  = '{32'h0022_1820, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 32'h0000_000C};
        vt[3]  = '{32'hAC23_0004, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 32'h0000_0010};
        vt[4]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 2, 0, 1'b0, 32'h0000_000C};
        vt[5]  = '{32'h2002_0001, 1'b0, 1'b0, 1'b0, 1, 5, 1'b0, 32'h0000_0010};
        vt[6]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 32'h0000_0014};
        vt[7]  = '{32'h0BFF_FFFF, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0, 32'h0FFF_FFFC};
        vt[8]  = '{32'h2003_0002, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 32'h1000_0000};
        vt[9]  = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 32'h1000_0100};
        vt[10] = '{32'h1022_0003, 1'b1, 1'b0, 1'b1, 4, 0, 1'b0, 32'h1000_0110};
        vt[11] = '{32'h1022_0003, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 32'h1000_0114};

        @(negedge clk);
        @(negedge clk);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_proto_err", {31'b0, proto_err}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_imem_addr_w", imem_addr_w, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        exp_pc_q.push_back(32'h0000_0000);
        @(negedge clk);
        chk("req_first_edge", {31'b0, imem_req}, 32'd1);

        for (int v = 0; v < 12; v++) begin
            wait_req(ok);
            if (!ok) break;
            check_fetch_addr($sformatf("fetch_addr[%0d]", v), e_pc);
            if (v == 0) chk("wrap_first_addr", imem_addr_w, 32'hFFFF_FFFC);
            if (v == 1) chk("wrap_next_addr", imem_addr_w, 32'h0000_0000);
            if (vt[v].rdy_early) instr_ready = 1'b1;

            for (int k = 0; k < vt[v].lat; k++) begin
                @(negedge clk);
                if (k == 0) chk($sformatf("req_pulse_len[%0d]", v), {31'b0, imem_req}, 32'd0);
            end
            imem_rvalid = 1'b1;
            imem_rdata  = vt[v].instr;
            exp_f_q.push_back('{vt[v].instr, e_pc});
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;

            chk($sformatf("instr_valid[%0d]", v), {31'b0, instr_valid}, 32'd1);
            f = exp_f_q.pop_front();
            chk($sformatf("instr[%0d]", v), instr, f.instr);
            chk($sformatf("opcode[%0d]", v), {26'b0, opcode}, {26'b0, f.instr[31:26]});
            chk($sformatf("instr_pc[%0d]", v), instr_pc, f.pc);
            chk($sformatf("proto_err[%0d]", v), {31'b0, proto_err}, (v > 5) ? 32'd1 : 32'd0);

            if (vt[v].stall > 0) begin
                instr_ready = 1'b0;
                for (int k = 0; k < vt[v].stall; k++) begin
                    branch = 1'($urandom_range(1));
                    jump   = 1'($urandom_range(1));
                    zero   = 1'($urandom_range(1));
                    if (k == 2) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = 32'hDEAD_BEEF;
                    end
                    @(negedge clk);
                    imem_rvalid = 1'b0;
                    chk($sformatf("stall_instr[%0d]", k), instr, f.instr);
                    chk($sformatf("stall_instr_pc[%0d]", k), instr_pc, f.pc);
                    chk($sformatf("stall_valid_req[%0d]", k), {30'b0, instr_valid, imem_req}, 32'd2);
                    chk($sformatf("stall_retired[%0d]", k), retired, 32'(v));
                end
                chk("proto_err_stray_in_valid", {31'b0, proto_err}, 32'd1);
            end

            instr_ready = 1'b1;
            branch      = vt[v].b;
            jump        = vt[v].j;
            zero        = vt[v].z;
            @(negedge clk);
            instr_ready = 1'b0;
            branch      = 1'b0;
            jump        = 1'b0;
            zero        = 1'b0;
            exp_pc_q.push_back(vt[v].exp_next);
            chk($sformatf("retired[%0d]", v), retired, 32'(v + 1));
            chk($sformatf("accept_state[%0d]", v), {30'b0, instr_valid, imem_req}, 32'd0);
        end

        wait_req(ok);
        check_fetch_addr("fetch_addr_final", e_pc);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, imem_req}, 32'd0);
        chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_rst_instr", instr, 32'd0);
        chk("async_rst_instr_pc", instr_pc, 32'd0);
        chk("async_rst_retired", retired, 32'd0);
        chk("async_rst_proto_err", {31'b0, proto_err}, 32'd0);
        chk("async_rst_addr", imem_addr, 32'd0);
        exp_pc_q.delete();

        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0001;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("stray_proto_err", {31'b0, proto_err}, 32'd1);
        chk("stray_instr", instr, 32'd0);
        chk("stray_valid", {31'b0, instr_valid}, 32'd0);
        chk("stray_req", {31'b0, imem_req}, 32'd1);
        chk("stray_addr", imem_addr, 32'd0);

        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2001_0005;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("post_rst_instr", instr, 32'h2001_0005);
        chk("post_rst_valid", {31'b0, instr_valid}, 32'd1);
        chk("post_rst_proto_sticky", {31'b0, proto_err}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
